// File: rtl/ble_power_pkg.sv
// Shared power-management types: requested power states, sequencer steps and
// the per-state domain control configuration.
package ble_power_pkg;

  typedef enum logic [1:0] {
    PS_SHUTDOWN  = 2'b00,
    PS_DEEPSLEEP = 2'b01,
    PS_SLEEP     = 2'b10,
    PS_ACTIVE    = 2'b11
  } pwr_state_t;

  // Step order matters: the sequencer advances by incrementing the encoding.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLK_OFF,
    ST_ISO_ON,
    ST_RET_SET,
    ST_PWR_OFF,
    ST_PWR_ON,
    ST_WAIT_PG,
    ST_RET_CLR,
    ST_ISO_OFF,
    ST_CLK_ON,
    ST_FAULT
  } seq_step_t;

  typedef struct packed {
    logic core;
    logic rf;
    logic iso;
    logic ret;
    logic clk;
  } pwr_cfg_t;

  localparam pwr_cfg_t CFG_SAFE = '{core: 1'b0, rf: 1'b0, iso: 1'b1, ret: 1'b0, clk: 1'b0};

endpackage

// File: rtl/pwr_target_decode.sv
// Maps a requested power state to its core/rf/iso/ret/clk target configuration.
module pwr_target_decode
  import ble_power_pkg::*;
(
  input  logic [1:0] power_state,
  output pwr_cfg_t   cfg
);

  always_comb begin
    cfg = CFG_SAFE;
    case (power_state)
      PS_ACTIVE:    cfg = '{core: 1'b1, rf: 1'b1, iso: 1'b0, ret: 1'b0, clk: 1'b1};
      PS_SLEEP:     cfg = '{core: 1'b1, rf: 1'b0, iso: 1'b1, ret: 1'b0, clk: 1'b0};
      PS_DEEPSLEEP: cfg = '{core: 1'b0, rf: 1'b0, iso: 1'b1, ret: 1'b1, clk: 1'b0};
      default:      cfg = CFG_SAFE;
    endcase
  end

endmodule

// File: rtl/power_domain_seq.sv
// Sequences clock-gate, isolation, retention and rail enables for the core and
// RF domains toward the requested power state, waiting on rail power-good.
//
// state      | meaning
// IDLE       | compare request with cur_state, latch target on mismatch
// CLK_OFF    | gate functional clock if target needs it off
// ISO_ON     | enable isolation clamps if target needs them
// RET_SET    | assert retention if target needs it
// PWR_OFF    | drop rails the target turns off
// PWR_ON     | raise rails the target turns on
// WAIT_PG    | wait for power-good on enabled rails, bounded by PG_TIMEOUT
// RET_CLR    | release retention if target clears it
// ISO_OFF    | release isolation if target clears it
// CLK_ON     | ungate clock if target needs it; completion on exit
// FAULT      | safe state, sticky until reset
module power_domain_seq
  import ble_power_pkg::*;
#(
  parameter int STEP_DLY   = 4,
  parameter int PG_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] power_state,
  input  logic       pgood_core,
  input  logic       pgood_rf,
  output logic       pwr_en_core,
  output logic       pwr_en_rf,
  output logic       iso_en,
  output logic       ret_en,
  output logic       clk_en,
  output logic [1:0] cur_state,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       fault
);

  localparam int CNT_MAX = (STEP_DLY > PG_TIMEOUT) ? STEP_DLY : PG_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] PG_LOAD   = CNT_W'(PG_TIMEOUT - 1);

  seq_step_t        step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwr_cfg_t         req_cfg, tgt_q, tgt_d, ctl_q, ctl_d;
  logic [1:0]       tgt_state_q, tgt_state_d, cur_q, cur_d;
  logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic             pg_ok, chg;

  pwr_target_decode u_decode (
    .power_state (power_state),
    .cfg         (req_cfg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q      <= ST_IDLE;
      cnt_q       <= '0;
      tgt_q       <= CFG_SAFE;
      tgt_state_q <= 2'b00;
      ctl_q       <= CFG_SAFE;
      cur_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      tgt_state_q <= tgt_state_d;
      ctl_q       <= ctl_d;
      cur_q       <= cur_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    step_d      = step_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    tgt_state_d = tgt_state_q;
    ctl_d       = ctl_q;
    cur_d       = cur_q;
    fault_d     = fault_q;
    done_d      = 1'b0;
    chg         = 1'b0;
    pg_ok       = (pgood_core | ~ctl_q.core) & (pgood_rf | ~ctl_q.rf);

    case (step_q)
      ST_IDLE: begin
        if ((power_state != cur_q) && !fault_q) begin
          tgt_d       = req_cfg;
          tgt_state_d = power_state;
          step_d      = ST_CLK_OFF;
        end
      end
      ST_WAIT_PG: begin
        // Power-good is tested before the timeout so a late rise still wins.
        if (pg_ok)              step_d = ST_RET_CLR;
        else if (cnt_q == '0)   step_d = ST_FAULT;
      end
      ST_CLK_ON: begin
        if (cnt_q == '0) begin
          step_d = ST_IDLE;
          cur_d  = tgt_state_q;
          done_d = 1'b1;
        end
      end
      ST_FAULT: step_d = ST_FAULT;
      default: begin
        if (cnt_q == '0) step_d = seq_step_t'(step_q + 4'd1);
      end
    endcase

    // Each step's control change is applied on the edge that enters it.
    if (step_d != step_q) begin
      case (step_d)
        ST_CLK_OFF: begin
          chg       = ctl_q.clk & ~tgt_d.clk;
          ctl_d.clk = ctl_q.clk & tgt_d.clk;
        end
        ST_ISO_ON: begin
          chg       = ~ctl_q.iso & tgt_d.iso;
          ctl_d.iso = ctl_q.iso | tgt_d.iso;
        end
        ST_RET_SET: begin
          chg       = ~ctl_q.ret & tgt_d.ret;
          ctl_d.ret = ctl_q.ret | tgt_d.ret;
        end
        ST_PWR_OFF: begin
          chg        = (ctl_q.core & ~tgt_d.core) | (ctl_q.rf & ~tgt_d.rf);
          ctl_d.core = ctl_q.core & tgt_d.core;
          ctl_d.rf   = ctl_q.rf & tgt_d.rf;
        end
        ST_PWR_ON: begin
          chg        = (~ctl_q.core & tgt_d.core) | (~ctl_q.rf & tgt_d.rf);
          ctl_d.core = ctl_q.core | tgt_d.core;
          ctl_d.rf   = ctl_q.rf | tgt_d.rf;
        end
        ST_RET_CLR: begin
          chg       = ctl_q.ret & ~tgt_d.ret;
          ctl_d.ret = ctl_q.ret & tgt_d.ret;
        end
        ST_ISO_OFF: begin
          chg       = ctl_q.iso & ~tgt_d.iso;
          ctl_d.iso = ctl_q.iso & tgt_d.iso;
        end
        ST_CLK_ON: begin
          chg       = ~ctl_q.clk & tgt_d.clk;
          ctl_d.clk = ctl_q.clk | tgt_d.clk;
        end
        ST_FAULT: begin
          ctl_d   = CFG_SAFE;
          fault_d = 1'b1;
        end
        default: chg = 1'b0;
      endcase
      if (step_d == ST_WAIT_PG) cnt_d = PG_LOAD;
      else                      cnt_d = chg ? STEP_LOAD : '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    busy_d = (step_d != ST_IDLE);
  end

  assign pwr_en_core = ctl_q.core;
  assign pwr_en_rf   = ctl_q.rf;
  assign iso_en      = ctl_q.iso;
  assign ret_en      = ctl_q.ret;
  assign clk_en      = ctl_q.clk;
  assign cur_state   = cur_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_power_domain_seq.sv
// Directed bench for power_domain_seq: stimulus pushes expected completion and
// fault events; a negedge monitor pops and checks them against the outputs.
module tb_power_domain_seq;

  localparam int STEP_DLY   = 4;
  localparam int PG_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] power_state = 2'b00;
  logic       pgood_core = 1'b0;
  logic       pgood_rf = 1'b0;
  logic       pwr_en_core, pwr_en_rf, iso_en, ret_en, clk_en;
  logic [1:0] cur_state;
  logic       seq_busy, seq_done, fault;

  power_domain_seq #(.STEP_DLY(STEP_DLY), .PG_TIMEOUT(PG_TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .power_state (power_state),
    .pgood_core  (pgood_core),
    .pgood_rf    (pgood_rf),
    .pwr_en_core (pwr_en_core),
    .pwr_en_rf   (pwr_en_rf),
    .iso_en      (iso_en),
    .ret_en      (ret_en),
    .clk_en      (clk_en),
    .cur_state   (cur_state),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         kind;   // 0 = seq_done, 1 = fault rise
    int         at;
    logic [1:0] cur;
    logic [4:0] ctl;    // core rf iso ret clk
  } exp_t;
  exp_t sb[$];

  function automatic logic [4:0] ctl_now();
    return {pwr_en_core, pwr_en_rf, iso_en, ret_en, clk_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int kind, input int at, input logic [1:0] cur, input logic [4:0] ctl);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    e.cur  = cur;
    e.ctl  = ctl;
    sb.push_back(e);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  logic fault_prev = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (seq_done || (fault && !fault_prev)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: done=%0b fault=%0b with no expected event (cycle %0d)",
                 seq_done, fault, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_kind", seq_done ? 0 : 1, e.kind);
        chk("event_cycle", cyc, e.at);
        chk("event_cur_state", cur_state, e.cur);
        chk("event_controls", ctl_now(), e.ctl);
      end
    end
    fault_prev = fault;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_controls", ctl_now(), 5'b00100);
    chk("rst_cur_state", cur_state, 2'b00);
    chk("rst_busy", seq_busy, 1'b0);
    chk("rst_fault", fault, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", seq_busy, 1'b0);
    end
    chk("idle_controls", ctl_now(), 5'b00100);

    // SHUTDOWN -> DEEPSLEEP
    t0 = cyc;
    power_state = 2'b01;
    expect_evt(0, t0 + 13, 2'b01, 5'b00110);
    at(t0 + 1);  chk("s2d_busy_rise", seq_busy, 1'b1);
    at(t0 + 2);  chk("s2d_ret_before", ret_en, 1'b0);
    at(t0 + 3);  chk("s2d_ret_rise", ret_en, 1'b1);
    at(t0 + 16); chk("s2d_busy_after", seq_busy, 1'b0);

    // DEEPSLEEP -> ACTIVE, power-good 10 cycles after rails enable
    t0 = cyc;
    power_state = 2'b11;
    expect_evt(0, t0 + 28, 2'b11, 5'b11001);
    at(t0 + 4);  chk("d2a_rails_before", {pwr_en_core, pwr_en_rf}, 2'b00);
    at(t0 + 5);  chk("d2a_rails_rise", {pwr_en_core, pwr_en_rf}, 2'b11);
    at(t0 + 15);
    chk("d2a_wait_hold", {iso_en, ret_en, clk_en}, 3'b110);
    pgood_core = 1'b1;
    pgood_rf   = 1'b1;
    at(t0 + 16); chk("d2a_ret_fall", {iso_en, ret_en}, 2'b10);
    at(t0 + 19); chk("d2a_iso_before", iso_en, 1'b1);
    at(t0 + 20); chk("d2a_iso_fall", {iso_en, clk_en}, 2'b00);
    at(t0 + 23); chk("d2a_clk_before", clk_en, 1'b0);
    at(t0 + 24); chk("d2a_clk_rise", clk_en, 1'b1);
    at(t0 + 30);

    // ACTIVE -> SLEEP
    t0 = cyc;
    power_state = 2'b10;
    expect_evt(0, t0 + 19, 2'b10, 5'b10100);
    at(t0 + 1);  chk("a2s_clk_fall", {clk_en, iso_en}, 2'b00);
    at(t0 + 4);  chk("a2s_iso_before", iso_en, 1'b0);
    at(t0 + 5);  chk("a2s_iso_rise", iso_en, 1'b1);
    at(t0 + 9);  chk("a2s_rf_before", pwr_en_rf, 1'b1);
    at(t0 + 10); chk("a2s_rf_fall", {pwr_en_core, pwr_en_rf, ret_en}, 3'b100);
    at(t0 + 21);

    // SLEEP -> ACTIVE with RF power-good stuck low
    pgood_rf = 1'b0;
    t0 = cyc;
    power_state = 2'b11;
    expect_evt(1, t0 + 73, 2'b10, 5'b00100);
    at(t0 + 5);  chk("s2a_rf_rise", pwr_en_rf, 1'b1);
    at(t0 + 72); chk("s2a_no_fault_yet", {fault, pwr_en_rf}, 2'b01);
    at(t0 + 73); chk("s2a_fault", {fault, seq_busy}, 2'b11);
    power_state = 2'b00;
    repeat (20) @(negedge clk);
    chk("fault_sticky", {fault, seq_busy, seq_done}, 3'b110);
    chk("fault_controls", ctl_now(), 5'b00100);
    chk("fault_cur_state", cur_state, 2'b10);

    // Reset clears fault immediately
    #2 reset_n = 1'b0;
    #1;
    chk("rst_fault_clear", {fault, seq_busy}, 2'b00);
    chk("rst_fault_controls", ctl_now(), 5'b00100);
    chk("rst_fault_cur", cur_state, 2'b00);
    @(negedge clk);
    pgood_core = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Request change mid-sequence: DEEPSLEEP completes, then SHUTDOWN
    t0 = cyc;
    power_state = 2'b01;
    expect_evt(0, t0 + 13, 2'b01, 5'b00110);
    expect_evt(0, t0 + 26, 2'b00, 5'b00100);
    at(t0 + 5);  power_state = 2'b00;
    at(t0 + 13); chk("b2b_idle_gap", seq_busy, 1'b0);
    at(t0 + 14); chk("b2b_restart", seq_busy, 1'b1);
    at(t0 + 19); chk("b2b_ret_hold", ret_en, 1'b1);
    at(t0 + 20); chk("b2b_ret_clr", ret_en, 1'b0);
    at(t0 + 28);

    // Asynchronous reset in the middle of a step
    t0 = cyc;
    power_state = 2'b01;
    at(t0 + 4);  chk("mid_ret_set", ret_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_controls", ctl_now(), 5'b00100);
    chk("mid_rst_status", {seq_busy, seq_done, cur_state}, 4'b0000);
    @(negedge clk);
    power_state = 2'b00;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_stays_idle", seq_busy, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
